// File: rtl/alu_pkg.sv
// Shared opcode encoding for the ALU and anything that drives it.
// Opcodes 11..15 are reserved and evaluate to zero.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_ADD = 4'd0;
    localparam opcode_t OP_SUB = 4'd1;
    localparam opcode_t OP_MUL = 4'd2;
    localparam opcode_t OP_SHR = 4'd3;
    localparam opcode_t OP_SHL = 4'd4;
    localparam opcode_t OP_DIV = 4'd5;
    localparam opcode_t OP_NOT = 4'd6;
    localparam opcode_t OP_AND = 4'd7;
    localparam opcode_t OP_OR  = 4'd8;
    localparam opcode_t OP_XOR = 4'd9;
    localparam opcode_t OP_ONE = 4'd10;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode bus into the ALU and its registered result/conditional bit back out.
// The master drives operands; the slave (the ALU) returns results one cycle later.
interface alu_if #(
    parameter int WIDTH     = 8,
    parameter int MUL_WIDTH = 12
) ();
    import alu_pkg::*;

    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    opcode_t              opsel;
    logic                 in;
    logic                 cond1;
    logic                 cond2;
    logic [MUL_WIDTH-1:0] result;
    logic                 out;

    modport master (
        output a, b, opsel, in, cond1, cond2,
        input  result, out
    );

    modport slave (
        input  a, b, opsel, in, cond1, cond2,
        output result, out
    );

endinterface

// File: rtl/alu_div.sv
// Combinational unsigned WIDTH/WIDTH restoring divider, fully unrolled so it
// settles within a single clock period. Divide-by-zero is flagged separately.
module alu_div #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quotient,
    output logic             o_div_by_zero
);

    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_quo;

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_rem = '0;
        w_quo = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            w_rem = {w_rem[WIDTH-1:0], i_dividend[i]};
            if (w_rem >= {1'b0, i_divisor}) begin
                w_rem    = w_rem - {1'b0, i_divisor};
                w_quo[i] = 1'b1;
            end
        end
    end

    assign o_quotient    = w_quo;
    assign o_div_by_zero = (i_divisor == '0);

endmodule

// File: rtl/alu.sv
// Registered integer ALU: zero-extended unsigned operands, MUL_WIDTH-wide result
// modulo 2^MUL_WIDTH, plus an independent priority-selected conditional bit.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MUL_WIDTH = 12
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    logic [MUL_WIDTH-1:0] w_a_ext;
    logic [MUL_WIDTH-1:0] w_b_ext;
    logic                 w_shift_oob;
    logic [WIDTH-1:0]     w_quotient;
    logic                 w_div_by_zero;
    logic [MUL_WIDTH-1:0] w_next_result;
    logic                 w_next_out;

    logic [MUL_WIDTH-1:0] r_result;
    logic                 r_out;

    assign w_a_ext     = MUL_WIDTH'(bus.a);
    assign w_b_ext     = MUL_WIDTH'(bus.b);
    // Shift amounts at or beyond the result width flush every bit out.
    assign w_shift_oob = (w_b_ext >= MUL_WIDTH'(MUL_WIDTH));

    alu_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .i_dividend    (bus.a),
        .i_divisor     (bus.b),
        .o_quotient    (w_quotient),
        .o_div_by_zero (w_div_by_zero)
    );

    always_comb begin
        w_next_result = '0;
        case (bus.opsel)
            OP_ADD: w_next_result = w_a_ext + w_b_ext;
            OP_SUB: w_next_result = w_a_ext - w_b_ext;
            OP_MUL: w_next_result = w_a_ext * w_b_ext;
            OP_SHR: w_next_result = w_shift_oob ? '0 : (w_a_ext >> w_b_ext);
            OP_SHL: w_next_result = w_shift_oob ? '0 : (w_a_ext << w_b_ext);
            OP_DIV: w_next_result = w_div_by_zero ? '1 : MUL_WIDTH'(w_quotient);
            OP_NOT: w_next_result = ~w_a_ext;
            OP_AND: w_next_result = w_a_ext & w_b_ext;
            OP_OR:  w_next_result = w_a_ext | w_b_ext;
            OP_XOR: w_next_result = w_a_ext ^ w_b_ext;
            OP_ONE: w_next_result = MUL_WIDTH'(1);
            default: w_next_result = '0;
        endcase
    end

    always_comb begin
        w_next_out = 1'b0;
        if (bus.cond1) begin
            w_next_out = bus.in;
        end else if (bus.cond2) begin
            w_next_out = ~bus.in;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_out    <= 1'b0;
        end else begin
            r_result <= w_next_result;
            r_out    <= w_next_out;
        end
    end

    assign bus.result = r_result;
    assign bus.out    = r_out;

endmodule

// File: tb/tb_alu.sv
// Directed and randomised self-checking bench for alu (WIDTH=8, MUL_WIDTH=12).
module tb_alu;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    alu_if #(.WIDTH(8), .MUL_WIDTH(12)) bus ();

    alu #(.WIDTH(8), .MUL_WIDTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive one operation at the falling edge, then settle just after the next rising edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic in_b, input logic c1, input logic c2);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.opsel = op;
        bus.in    = in_b;
        bus.cond1 = c1;
        bus.cond2 = c2;
        @(posedge clk);
        #1;
    endtask

    // Independent arithmetic reference for 8-bit operands and a 12-bit result.
    function automatic int ref_result(input int a, input int b, input int op);
        case (op)
            0:  return (a + b) % 4096;
            1:  return (a - b + 4096) % 4096;
            2:  return (a * b) % 4096;
            3:  return (b >= 12) ? 0 : (a / (1 << b));
            4:  return (b >= 12) ? 0 : ((a * (1 << b)) % 4096);
            5:  return (b == 0) ? 4095 : (a / b);
            6:  return 4095 - a;
            7:  return a & b;
            8:  return a | b;
            9:  return a ^ b;
            10: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_out(input logic in_b, input logic c1, input logic c2);
        if (c1) return in_b;
        if (c2) return ~in_b;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.a     = 8'hA5;
        bus.b     = 8'h3C;
        bus.opsel = 4'd2;
        bus.in    = 1'b1;
        bus.cond1 = 1'b1;
        bus.cond2 = 1'b0;
        #2;
        checks++;
        if (bus.result !== 12'd0 || bus.out !== 1'b0) begin
            failures++;
            $display("FAIL reset_initial result=%0d out=%0b expected result=0 out=0", bus.result, bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(8'd103, 8'd84, 4'd0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus.result !== 12'd187 || bus.out !== 1'b1) begin
            failures++;
            $display("FAIL first_after_reset result=%0d out=%0b expected result=187 out=1", bus.result, bus.out);
        end
        // Assert reset between clock edges: outputs must clear without waiting for clk.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.result !== 12'd0 || bus.out !== 1'b0) begin
            failures++;
            $display("FAIL async_reset result=%0d out=%0b expected result=0 out=0", bus.result, bus.out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        int ops [9] = '{1, 2, 2, 5, 5, 5, 0, 1, 2};
        int av  [9] = '{63, 39, 255, 102, 77, 200, 255, 0, 64};
        int bv  [9] = '{70, 31, 255, 119, 0, 7, 255, 1, 64};
        int ex  [9] = '{12'hFF9, 1209, 12'hE01, 0, 12'hFFF, 28, 510, 12'hFFF, 0};
        for (int i = 0; i < 9; i++) begin
            drive(8'(av[i]), 8'(bv[i]), 4'(ops[i]), 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.result !== 12'(ex[i])) begin
                failures++;
                $display("FAIL arith[%0d] op=%0d a=%0d b=%0d got=%0d expected=%0d",
                         i, ops[i], av[i], bv[i], bus.result, ex[i]);
            end
        end
    endtask

    task automatic test_shift_logic();
        int ops [12] = '{3, 4, 6, 7, 8, 9, 3, 4, 4, 4, 3, 3};
        int av  [12] = '{62, 27, 90, 91, 9, 8, 200, 255, 1, 1, 128, 255};
        int bv  [12] = '{109, 2, 0, 107, 6, 71, 3, 4, 11, 12, 7, 11};
        int ex  [12] = '{0, 108, 4005, 75, 15, 79, 25, 4080, 2048, 0, 1, 0};
        for (int i = 0; i < 12; i++) begin
            drive(8'(av[i]), 8'(bv[i]), 4'(ops[i]), 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.result !== 12'(ex[i])) begin
                failures++;
                $display("FAIL shift_logic[%0d] op=%0d a=%0d b=%0d got=%0d expected=%0d",
                         i, ops[i], av[i], bv[i], bus.result, ex[i]);
            end
        end
    endtask

    task automatic test_constants();
        for (int op = 10; op < 16; op++) begin
            drive(8'hAA, 8'h55, 4'(op), 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.result !== ((op == 10) ? 12'd1 : 12'd0)) begin
                failures++;
                $display("FAIL const op=%0d got=%0d expected=%0d", op, bus.result, (op == 10) ? 1 : 0);
            end
        end
    endtask

    task automatic test_cond();
        logic c1v [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic c2v [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic inv [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic ex  [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            drive(8'd5, 8'd3, 4'd0, inv[i], c1v[i], c2v[i]);
            checks++;
            if (bus.out !== ex[i] || bus.result !== 12'd8) begin
                failures++;
                $display("FAIL cond[%0d] c1=%0b c2=%0b in=%0b got out=%0b result=%0d expected out=%0b result=8",
                         i, c1v[i], c2v[i], inv[i], bus.out, bus.result, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        logic [3:0] op;
        logic       in_b, c1, c2;
        for (int i = 0; i < 40; i++) begin
            a    = 8'($urandom_range(0, 255));
            b    = (i % 5 == 0) ? 8'($urandom_range(0, 13)) : 8'($urandom_range(0, 255));
            op   = 4'($urandom_range(0, 15));
            in_b = 1'($urandom_range(0, 1));
            c1   = 1'($urandom_range(0, 1));
            c2   = 1'($urandom_range(0, 1));
            drive(a, b, op, in_b, c1, c2);
            checks++;
            if (bus.result !== 12'(ref_result(int'(a), int'(b), int'(op))) || bus.out !== ref_out(in_b, c1, c2)) begin
                failures++;
                $display("FAIL random[%0d] op=%0d a=%0d b=%0d got=%0d/%0b expected=%0d/%0b", i, op, a, b,
                         bus.result, bus.out, ref_result(int'(a), int'(b), int'(op)), ref_out(in_b, c1, c2));
            end
            if (i == 20) begin
                #2;
                rst_n = 1'b0;
                #1;
                checks++;
                if (bus.result !== 12'd0 || bus.out !== 1'b0) begin
                    failures++;
                    $display("FAIL random_reset result=%0d out=%0b expected result=0 out=0", bus.result, bus.out);
                end
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift_logic();
        test_constants();
        test_cond();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
